alu_issue: RTL and testbench



---
 rtl/alu_issue.sv | 149 ++++++++++++++
 tb/tb_alu_issue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// ALU issue stage: decodes the RV64 integer ALU subset into operands and an op code,
// then holds the results in a 2-entry registered FIFO that feeds the ALU/writeback.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [63:0] pc,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] A,
  output logic [63:0] B,
  output logic [2:0]  ALU_C,
  output logic [4:0]  rd,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm_i;
  logic [63:0] imm_u;
  logic        legal;
  entry_t      dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{52{instr[31]}}, instr[31:20]};
  assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'b0};

  always_comb begin
    dec    = '0;
    legal  = 1'b0;
    dec.rd = instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec.a = rs1_data;
        dec.b = rs2_data;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  dec.op = ALU_ADD;
            3'b100:  dec.op = ALU_XOR;
            3'b110:  dec.op = ALU_OR;
            3'b111:  dec.op = ALU_AND;
            default: legal  = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal  = 1'b1;
          dec.op = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        dec.a = rs1_data;
        dec.b = imm_i;
        legal = 1'b1;
        case (funct3)
          3'b000:  dec.op = ALU_ADD;
          3'b100:  dec.op = ALU_XOR;
          3'b110:  dec.op = ALU_OR;
          3'b111:  dec.op = ALU_AND;
          default: legal  = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.b  = imm_u;
        dec.op = ALU_ADD;
        legal  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a  = pc;
        dec.b  = imm_u;
        dec.op = ALU_ADD;
        legal  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Unsupported tokens still flow through in order so writeback can trap on them.
    if (!legal) begin
      dec.a   = '0;
      dec.b   = '0;
      dec.op  = ALU_ADD;
      dec.ill = 1'b1;
    end
  end

  entry_t     mem [0:1];
  logic       head;
  logic       tail;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= dec;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign A       = mem[head].a;
  assign B       = mem[head].b;
  assign ALU_C   = mem[head].op;
  assign rd      = mem[head].rd;
  assign illegal = mem[head].ill;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed decode/backpressure/reset cases plus random traffic.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  ALU_C;
  logic [4:0]  rd;
  logic        illegal;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALU_C(ALU_C), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the instruction-set rules with plain arithmetic.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p,
                                 input logic [63:0] r1, input logic [63:0] r2);
    exp_t   e;
    longint imm_i;
    longint imm_u;
    int     f3;
    int     f7;
    bit     ok;
    imm_i = longint'(i[31:20]);
    if (i[31]) imm_i = imm_i - 4096;
    imm_u = longint'(i[31:12]) * 4096;
    if (i[31]) imm_u = imm_u - 64'h1_0000_0000;
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    e.rd = i[11:7];
    e.a = 0; e.b = 0; e.op = 0; e.ill = 0;
    ok = 0;
    case (i[6:0])
      7'h33: begin
        e.a = r1; e.b = r2;
        if (f7 == 0 && f3 == 0) begin ok = 1; e.op = 0; end
        if (f7 == 32 && f3 == 0) begin ok = 1; e.op = 1; end
        if (f7 == 0 && f3 == 4) begin ok = 1; e.op = 4; end
        if (f7 == 0 && f3 == 6) begin ok = 1; e.op = 3; end
        if (f7 == 0 && f3 == 7) begin ok = 1; e.op = 2; end
      end
      7'h13: begin
        e.a = r1; e.b = imm_i;
        if (f3 == 0) begin ok = 1; e.op = 0; end
        if (f3 == 4) begin ok = 1; e.op = 4; end
        if (f3 == 6) begin ok = 1; e.op = 3; end
        if (f3 == 7) begin ok = 1; e.op = 2; end
      end
      7'h37: begin ok = 1; e.a = 0; e.b = imm_u; e.op = 0; end
      7'h17: begin ok = 1; e.a = p; e.b = imm_u; e.op = 0; end
      default: ok = 0;
    endcase
    if (!ok) begin e.a = 0; e.b = 0; e.op = 0; e.ill = 1; end
    return e;
  endfunction

  // Monitor and scoreboard: the queue size mirrors the DUT occupancy at each falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        chk("A", A, q[0].a);
        chk("B", B, q[0].b);
        chk("ALU_C", ALU_C, q[0].op);
        chk("rd", rd, q[0].rd);
        chk("illegal", illegal, q[0].ill);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(instr, pc, rs1_data, rs2_data));
    end
  end

  task automatic issue(input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] r1, input logic [63:0] r2);
    int n;
    instr = i; pc = p; rs1_data = r1; rs2_data = r2;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_wait", n < 50, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_head(input string name, input logic [63:0] ea, input logic [63:0] eb,
                            input logic [2:0] ec, input logic [4:0] erd, input logic eill);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_A"}, A, ea);
    chk({name, "_B"}, B, eb);
    chk({name, "_C"}, ALU_C, ec);
    chk({name, "_rd"}, rd, erd);
    chk({name, "_ill"}, illegal, eill);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  r_d;
    logic [4:0]  r_1;
    logic [4:0]  r_2;
    logic [2:0]  f3;
    logic [31:0] w;
    logic [2:0]  legal_f3 [4];
    legal_f3 = '{3'b000, 3'b100, 3'b110, 3'b111};
    r_d = 5'($urandom); r_1 = 5'($urandom); r_2 = 5'($urandom);
    w = $urandom;
    case ($urandom_range(0, 8))
      0: w = {7'b0, r_2, r_1, legal_f3[$urandom_range(0, 3)], r_d, 7'h33};
      1: w = {7'h20, r_2, r_1, 3'b000, r_d, 7'h33};
      2: begin f3 = 3'($urandom); w = {w[31:20], r_1, f3, r_d, 7'h13}; end
      3: w = {w[31:12], r_d, 7'h37};
      4: w = {w[31:12], r_d, 7'h17};
      5: begin
        f3 = 3'($urandom);
        w = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom), r_2, r_1, f3, r_d, 7'h33};
      end
      6: w = $urandom;
      7: w = {w[31:2], 2'b11};
      default: w = {w[31:20], r_1, legal_f3[$urandom_range(0, 3)], r_d, 7'h13};
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_A", A, 0);
    chk("reset_B", B, 0);
    chk("reset_C", ALU_C, 0);
    chk("reset_rd", rd, 0);
    chk("reset_ill", illegal, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'hFFF00093, 64'h0, 64'd5, 64'h0);
    in_valid = 1'b0;
    @(negedge clk);
    check_head("addi", 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 5'd1, 1'b0);
    @(posedge clk); #1;

    issue(32'h40208133, 64'h0, 64'd10, 64'd3);
    in_valid = 1'b0;
    @(negedge clk);
    check_head("sub", 64'd10, 64'd3, 3'b001, 5'd2, 1'b0);
    @(posedge clk); #1;

    issue(32'h800000B7, 64'h0, 64'h1234, 64'h5678);
    in_valid = 1'b0;
    @(negedge clk);
    check_head("lui", 64'h0, 64'hFFFF_FFFF_8000_0000, 3'b000, 5'd1, 1'b0);
    @(posedge clk); #1;

    issue(32'h00001117, 64'h8000_0000, 64'h1, 64'h2);
    in_valid = 1'b0;
    @(negedge clk);
    check_head("auipc", 64'h8000_0000, 64'h1000, 3'b000, 5'd2, 1'b0);
    @(posedge clk); #1;

    issue(32'h00000073, 64'h40, 64'h11, 64'h22);
    issue(32'h00209033, 64'h44, 64'h33, 64'h44);
    in_valid = 1'b0;
    @(negedge clk);
    check_head("sll", 64'h0, 64'h0, 3'b000, 5'd0, 1'b1);
    @(posedge clk); #1;

    // Backpressure: xor and or fill the buffer, and must wait.
    out_ready = 1'b0;
    issue(32'h0020C1B3, 64'h0, 64'hF0F0, 64'h0FF0);
    issue(32'h0020E1B3, 64'h0, 64'hF0F0, 64'h0FF0);
    instr = 32'h0020F1B3; rs1_data = 64'hF0F0; rs2_data = 64'h0FF0;
    in_valid = 1'b1;
    chk("full_in_ready", in_ready, 0);
    @(negedge clk);
    check_head("bp_xor", 64'hF0F0, 64'h0FF0, 3'b100, 5'd3, 1'b0);
    @(posedge clk); #1;
    chk("full_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("full_pop_same_cycle", in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_pop", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset with two entries held discards them.
    out_ready = 1'b0;
    issue(gen_instr(), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    issue(gen_instr(), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    in_valid = 1'b0;
    chk("pre_reset_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_in_ready", in_ready, 1);
    chk("mid_reset_A", A, 0);
    chk("mid_reset_C", ALU_C, 0);
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_valid", out_valid, 0);

    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = gen_instr();
      pc        = {$urandom, $urandom};
      rs1_data  = {$urandom, $urandom};
      rs2_data  = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drained", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
